// File: rtl/io_write_arbiter.sv
// Two-requester round-robin write arbiter feeding a single memory-mapped output port.
// Each transaction runs IDLE -> ISSUE (strobe) -> DONE (ack/err); requests are sampled only in IDLE.
module io_write_arbiter #(
  parameter logic [5:0] OUT_ADDR = 6'b101010
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] data0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [31:0] addr,
  output logic [31:0] datain,
  output logic        write_io_enable,
  output logic        grant_id,
  output logic [15:0] wr_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_id_q, grant_id_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wen_q, wen_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err_q, err_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic        gnt;
  logic [31:0] sel_addr;
  logic [31:0] sel_data;

  // Only the word index and byte offset decode; upper address bits alias.
  function automatic logic addr_ok(input logic [7:0] a);
    return (a[7:2] == OUT_ADDR) && (a[1:0] == 2'b00);
  endfunction

  // On a tie, the requester that did not win last time gets the grant.
  assign gnt      = (req0 && req1) ? ~last_grant_q : req1;
  assign sel_addr = gnt ? addr1 : addr0;
  assign sel_data = gnt ? data1 : data0;

  always_ff @(posedge io_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      addr_q       <= 32'h0;
      data_q       <= 32'h0;
      wen_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
      wr_count_q   <= 16'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wen_q        <= wen_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err_q        <= err_d;
      wr_count_q   <= wr_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wen_d        = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err_d        = 1'b0;
    wr_count_d   = wr_count_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d      = ISSUE;
          grant_id_d   = gnt;
          last_grant_d = gnt;
          addr_d       = sel_addr;
          data_d       = sel_data;
          wen_d        = addr_ok(sel_addr[7:0]);
        end
      end
      ISSUE: begin
        state_d = DONE;
        ack0_d  = ~grant_id_q;
        ack1_d  = grant_id_q;
        err_d   = ~addr_ok(addr_q[7:0]);
        if (wen_q) begin
          wr_count_d = wr_count_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack0            = ack0_q;
  assign ack1            = ack1_q;
  assign err             = err_q;
  assign addr            = addr_q;
  assign datain          = data_q;
  assign write_io_enable = wen_q;
  assign grant_id        = grant_id_q;
  assign wr_count        = wr_count_q;

endmodule

// File: tb/tb_io_write_arbiter.sv
// Directed plus randomized bench for io_write_arbiter against a transaction-level model.
module tb_io_write_arbiter;

  localparam logic [5:0] OUT = 6'b101010;

  logic        io_clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] addr0, data0, addr1, data1;
  logic        ack0, ack1, err, write_io_enable, grant_id;
  logic [31:0] addr, datain;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  // Model state: who won last, how many good writes so far.
  logic        m_last;
  logic [15:0] m_count;

  io_write_arbiter dut (
    .io_clk(io_clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0),
    .req1(req1), .addr1(addr1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .err(err),
    .addr(addr), .datain(datain),
    .write_io_enable(write_io_enable), .grant_id(grant_id),
    .wr_count(wr_count)
  );

  always #5 io_clk = ~io_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_valid(input logic [31:0] a);
    return (a[7:2] == OUT) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return 32'hA8;
      1:       return {r[31:8], 8'hA8};
      2:       return {r[31:8], OUT, r[1:0]};
      default: return r;
    endcase
  endfunction

  // Called at a negedge with the DUT idle and at least one req raised.
  // Returns at the negedge of the following idle cycle, granted req dropped.
  task automatic do_txn();
    logic        g, v;
    logic [31:0] a, d;
    if (req0 && req1) g = ~m_last;
    else              g = req1;
    a      = g ? addr1 : addr0;
    d      = g ? data1 : data0;
    v      = addr_valid(a);
    m_last = g;

    @(negedge io_clk);
    chk("issue_wen", write_io_enable, v);
    chk("issue_addr", addr, a);
    chk("issue_data", datain, d);
    chk("issue_gid", grant_id, g);
    chk("issue_ack_err", {ack0, ack1, err}, 3'b000);
    if (v) m_count = m_count + 16'd1;
    // Latched values must not follow the requester after the grant.
    if (g) begin addr1 = $urandom; data1 = $urandom; end
    else   begin addr0 = $urandom; data0 = $urandom; end

    @(negedge io_clk);
    chk("done_ack0", ack0, !g);
    chk("done_ack1", ack1, g);
    chk("done_err", err, !v);
    chk("done_wen", write_io_enable, 1'b0);
    chk("done_addr_hold", addr, a);
    chk("done_data_hold", datain, d);
    chk("done_count", wr_count, m_count);
    if (g) req1 = 1'b0;
    else   req0 = 1'b0;

    @(negedge io_clk);
    chk("idle_pulses", {write_io_enable, ack0, ack1, err}, 4'b0000);
    chk("idle_count", wr_count, m_count);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wen"}, write_io_enable, 1'b0);
    chk({tag, "_acks_err"}, {ack0, ack1, err}, 3'b000);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_data"}, datain, 32'h0);
    chk({tag, "_count"}, wr_count, 16'h0);
    chk({tag, "_gid"}, grant_id, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; addr0 = '0; data0 = '0;
    req1 = 1'b0; addr1 = '0; data1 = '0;
    m_last = 1'b1; m_count = 16'h0;

    // Reset state
    repeat (2) @(negedge io_clk);
    chk_reset_state("reset");
    reset = 1'b0;
    @(negedge io_clk);
    chk("idle_noreq", {write_io_enable, ack0, ack1, err}, 4'b0000);

    // Tie straight after reset: requester 0 first, then alternating
    req0 = 1'b1; addr0 = 32'hA8; data0 = 32'h1111_0000;
    req1 = 1'b1; addr1 = 32'hA8; data1 = 32'h2222_0000;
    do_txn();
    chk("tie_first_gid", grant_id, 1'b0);
    req0 = 1'b1; addr0 = 32'hA8; data0 = 32'h1111_0001;
    do_txn();
    chk("tie_second_gid", grant_id, 1'b1);
    req1 = 1'b1; addr1 = 32'hA8; data1 = 32'h2222_0001;
    do_txn();
    chk("tie_third_gid", grant_id, 1'b0);
    do_txn();
    chk("tie_count", wr_count, 16'd4);

    // Single write
    req0 = 1'b1; addr0 = 32'hA8; data0 = 32'h1234;
    do_txn();
    chk("single_count", wr_count, 16'd5);

    // Bad word address on requester 1
    req1 = 1'b1; addr1 = 32'hAC; data1 = 32'hDEAD_BEEF;
    do_txn();
    chk("badaddr_count", wr_count, 16'd5);

    // Misaligned byte address on requester 0
    req0 = 1'b1; addr0 = 32'hA9; data0 = 32'hCAFE;
    do_txn();

    // Upper address bits alias onto the port
    req1 = 1'b1; addr1 = 32'hFFFF_12A8; data1 = 32'h0BAD_F00D;
    do_txn();

    // Reset in ISSUE aborts the write; held request is re-served afterwards
    req0 = 1'b1; addr0 = 32'hA8; data0 = 32'h5555;
    @(negedge io_clk);
    chk("abort_issue_wen", write_io_enable, 1'b1);
    reset = 1'b1;
    @(negedge io_clk);
    chk_reset_state("abort");
    m_count = 16'h0; m_last = 1'b1;
    reset = 1'b0;
    addr0 = 32'hA8; data0 = 32'h5555;
    do_txn();

    // Reset in DONE suppresses nothing already shown but must leave no pulse behind
    req1 = 1'b1; addr1 = 32'hA8; data1 = 32'h7777;
    repeat (2) @(negedge io_clk);
    reset = 1'b1;
    @(negedge io_clk);
    chk_reset_state("abort_done");
    m_count = 16'h0; m_last = 1'b1;
    reset = 1'b0;
    req1 = 1'b0;
    @(negedge io_clk);
    chk("post_abort_idle", {write_io_enable, ack0, ack1, err}, 4'b0000);

    // Counter wrap
    force dut.wr_count_q = 16'hFFFF;
    #1 release dut.wr_count_q;
    m_count = 16'hFFFF;
    chk("wrap_preload", wr_count, 16'hFFFF);
    req0 = 1'b1; addr0 = 32'hA8; data0 = 32'h0F0F;
    do_txn();
    chk("wrap_zero", wr_count, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      if (!req0 && ($urandom_range(0, 9) < 6)) begin
        req0 = 1'b1; addr0 = rand_addr(); data0 = $urandom;
      end
      if (!req1 && ($urandom_range(0, 9) < 6)) begin
        req1 = 1'b1; addr1 = rand_addr(); data1 = $urandom;
      end
      if (req0 || req1) begin
        do_txn();
      end else begin
        @(negedge io_clk);
        chk("rand_idle", {write_io_enable, ack0, ack1, err}, 4'b0000);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_write_arbiter.md
IO_WRITE_ARBITER -- requirements
Module: io_write_arbiter

Interface
REQ-001 Parameter OUT_ADDR, default 6'b101010, word index addr[7:2] of the single writable output port (byte address A8h).
REQ-002 io_clk  input  1  sole clock; all state updates on posedge io_clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge io_clk.
REQ-004 req0  input  1  requester 0 (CPU store path) write request; held high until ack0.
REQ-005 addr0  input  32  requester 0 byte address; stable while req0 high.
REQ-006 data0  input  32  requester 0 write data; stable while req0 high.
REQ-007 req1, addr1, data1  input  1/32/32  requester 1 (secondary master), same rules as requester 0.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-009 err  output  1  one-cycle pulse coincident with ack when the granted address was rejected.
REQ-010 addr  output  32  registered address to the output-port block.
REQ-011 datain  output  32  registered write data to the output-port block.
REQ-012 write_io_enable  output  1  registered one-cycle write strobe to the output-port block.
REQ-013 grant_id  output  1  index of the requester owning the current or most recent transaction.
REQ-014 wr_count  output  16  count of successful writes issued since reset.

Function
REQ-015 FSM states IDLE, ISSUE, DONE; transitions IDLE->ISSUE when any req is high, ISSUE->DONE unconditionally, DONE->IDLE unconditionally.
REQ-016 In IDLE with exactly one req high, that requester is granted; with both high, the requester not granted last is granted (round-robin via last_grant register).
REQ-017 On the IDLE->ISSUE transition, addr/data of the granted requester are latched into addr/datain and grant_id/last_grant are updated.
REQ-018 A latched address is valid iff addr[7:2]==OUT_ADDR and addr[1:0]==2'b00; addr[31:8] are ignored.
REQ-019 In ISSUE, write_io_enable is 1 for exactly one cycle if the address is valid, else 0.
REQ-020 In DONE, ack of the granted requester is 1 for exactly one cycle, the other ack is 0; err is 1 in DONE iff the address was invalid.
REQ-021 Latency: req sampled high in IDLE at cycle N -> write_io_enable at N+1 -> ack at N+2 -> IDLE at N+3; max throughput one write per 3 cycles.
REQ-022 Requests are not sampled in ISSUE or DONE; a requester drops req or presents a new transaction in the cycle after its ack.
REQ-023 A non-granted requester keeps its req high and is granted at the next IDLE; starvation is bounded to one transaction.
REQ-024 wr_count increments by 1 in each ISSUE cycle with write_io_enable=1, wrapping 16'hFFFF -> 16'h0000.
REQ-025 addr and datain hold their last latched values outside ISSUE.
REQ-026 Requester inputs changing while their req is high are ignored after latching.

Reset
REQ-027 While reset is high at a clock edge: state=IDLE; write_io_enable, ack0, ack1 and err=0; addr, datain and wr_count=0; grant_id=0; last_grant=1, so requester 0 wins the first tie.
REQ-028 Reset asserted in ISSUE or DONE aborts the transaction: no ack or err pulse follows, and the write strobe is not re-issued.
REQ-029 Reset has priority over all requests on the same edge.

Verification
REQ-030 Single write: req0=1, addr0=32'hA8, data0=32'h1234 in IDLE at N -> write_io_enable=1, addr=32'hA8, datain=32'h1234 at N+1; ack0=1, err=0 at N+2; wr_count=1.
REQ-031 Tie after reset: req0 and req1 both held -> requester 0 is served first (ack0), then requester 1 (ack1) three cycles later, alternating while both are held.
REQ-032 Bad address: req1=1, addr1=32'hAC -> no write_io_enable; ack1=1 and err=1 at N+2; wr_count unchanged.
REQ-033 Misaligned address: addr0=32'hA9 -> err=1 with ack0, no strobe.
REQ-034 Reset mid-operation: reset asserted in ISSUE -> next cycle is IDLE, all outputs 0, no ack; a held req is re-served from IDLE after reset falls.
REQ-035 Wrap: wr_count preloaded to 16'hFFFF via 65535 writes (or force) -> next valid write yields wr_count=16'h0000.
